riscv_core_dpath_vec_regfile_param: RTL

Parametrised vector register file for the riscvvec datapath. Two combinational read ports and one element-granular write port. Writes are predicated by a vector-length (vl) register and an optional mask register. A built-in clear sequencer zeroes the file one register per cycle after reset or on request, so no array-wide reset is needed. It sits between vector decode/operand fetch and vector writeback.

---
 rtl/riscvvec_vec_pkg.sv | 20 ++
 rtl/riscv_core_dpath_vec_elem_mask.sv | 25 ++
 rtl/riscv_core_dpath_vec_regfile_param.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscvvec_vec_pkg.sv
// Shared definitions for the riscvvec vector register file and the writeback stage.
package riscvvec_vec_pkg;

  localparam int DEF_NREGS    = 32;
  localparam int DEF_ELEN     = 32;
  localparam int DEF_NELEM    = 8;
  localparam int DEF_MASK_REG = 31;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Enable for element idx: inside the active vector length and not masked off.
  function automatic logic elem_en_f(input int unsigned idx, input int unsigned vl,
                                     input logic mbit, input logic wmasked);
    return (idx < vl) && (!wmasked || mbit);
  endfunction

endpackage

// File: rtl/riscv_core_dpath_vec_elem_mask.sv
// Per-element write enables (vl + mask predication) and old/new element merge.
module riscv_core_dpath_vec_elem_mask
  import riscvvec_vec_pkg::*;
#(
  parameter  int NELEM = DEF_NELEM,
  parameter  int ELEN  = DEF_ELEN,
  localparam int LW    = $clog2(NELEM) + 1,
  localparam int VW    = NELEM * ELEN
) (
  input  logic             wr_ok_i,
  input  logic [LW-1:0]    vl_i,
  input  logic [NELEM-1:0] mask_i,
  input  logic             wmasked_i,
  input  logic [VW-1:0]    old_i,
  input  logic [VW-1:0]    new_i,
  output logic [NELEM-1:0] en_o,
  output logic [VW-1:0]    merged_o
);

  for (genvar g = 0; g < NELEM; g++) begin : g_elem
    assign en_o[g] = wr_ok_i & elem_en_f(g, 32'(vl_i), mask_i[g], wmasked_i);
    assign merged_o[g*ELEN +: ELEN] = en_o[g] ? new_i[g*ELEN +: ELEN] : old_i[g*ELEN +: ELEN];
  end

endmodule

// File: rtl/riscv_core_dpath_vec_regfile_param.sv
// Vector register file: 2 combinational read ports, 1 predicated element-granular write
// port, vl register, and a one-register-per-cycle clear sequencer instead of array reset.
module riscv_core_dpath_vec_regfile_param
  import riscvvec_vec_pkg::*;
#(
  parameter  int NREGS    = DEF_NREGS,
  parameter  int ELEN     = DEF_ELEN,
  parameter  int NELEM    = DEF_NELEM,
  parameter  int MASK_REG = DEF_MASK_REG,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS),
  localparam int LW       = $clog2(NELEM) + 1,
  localparam int VW       = NELEM * ELEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    raddr0,
  output logic [VW-1:0]    rvec0,
  input  logic [AW-1:0]    raddr1,
  output logic [VW-1:0]    rvec1,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [VW-1:0]    wvec,
  input  logic             wmasked,
  input  logic             vl_wen,
  input  logic [LW-1:0]    vl_wdata,
  output logic [LW-1:0]    vl,
  output logic [NELEM-1:0] mask,
  input  logic             clr_req,
  output logic             clr_busy
);

  logic [VW-1:0]    regs_q [NREGS];
  clr_state_e       state_q;
  logic [AW-1:0]    clr_idx_q;
  logic             clr_busy_q;
  logic [LW-1:0]    vl_q;
  logic [LW-1:0]    vl_d;

  logic             wr_ok;
  logic             mask_gate;
  logic [NELEM-1:0] wr_en;
  logic [VW-1:0]    wr_merged;
  logic [VW-1:0]    rd0_gated, rd1_gated;

  assign vl       = vl_q;
  assign clr_busy = clr_busy_q;
  assign wr_ok    = wen & ~clr_busy_q & (waddr != '0);

  // Registers at or above the clear pointer are not yet zeroed, so reads mask them.
  assign rd0_gated = (raddr0 == '0 || (clr_busy_q && raddr0 >= clr_idx_q)) ? '0 : regs_q[raddr0];
  assign rd1_gated = (raddr1 == '0 || (clr_busy_q && raddr1 >= clr_idx_q)) ? '0 : regs_q[raddr1];
  assign mask_gate = clr_busy_q && (AW'(MASK_REG) >= clr_idx_q);

  for (genvar g = 0; g < NELEM; g++) begin : g_mask
    assign mask[g] = mask_gate ? 1'b0 : regs_q[MASK_REG][g*ELEN];
  end

  // wr_ok implies waddr is live and ungated, so the raw stored value is the correct old data.
  riscv_core_dpath_vec_elem_mask #(.NELEM(NELEM), .ELEN(ELEN)) u_elem_mask (
    .wr_ok_i   (wr_ok),
    .vl_i      (vl_q),
    .mask_i    (mask),
    .wmasked_i (wmasked),
    .old_i     (regs_q[waddr]),
    .new_i     (wvec),
    .en_o      (wr_en),
    .merged_o  (wr_merged)
  );

  assign rvec0 = (BYPASS != 0 && wr_ok && raddr0 == waddr) ? wr_merged : rd0_gated;
  assign rvec1 = (BYPASS != 0 && wr_ok && raddr1 == waddr) ? wr_merged : rd1_gated;

  assign vl_d = (vl_wdata > LW'(NELEM)) ? LW'(NELEM) : vl_wdata;

  always_ff @(posedge clk) begin
    if (clr_busy_q) regs_q[clr_idx_q] <= '0;
    else if (|wr_en) regs_q[waddr] <= wr_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= AW'(1);
      clr_busy_q <= 1'b1;
      vl_q       <= LW'(NELEM);
    end else begin
      if (vl_wen) vl_q <= vl_d;
      case (state_q)
        ST_IDLE: begin
          if (clr_req) begin
            state_q    <= ST_CLEAR;
            clr_idx_q  <= AW'(1);
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_idx_q == AW'(NREGS - 1)) begin
            state_q    <= ST_IDLE;
            clr_busy_q <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + AW'(1);
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
